// File: rtl/encoder_emulator_if.sv
// Bundle carrying the PWM-tick sample inputs and the emulated encoder
// outputs between the wheel controller side and the encoder emulator.
interface encoder_emulator_if #(
  parameter int DUTY_WIDTH = 8,
  parameter int POS_WIDTH  = 16
);
  logic                  ENCODER_EMULATOR_PWMTICK_In;
  logic                  ENCODER_EMULATOR_PWM_In;
  logic [1:0]            ENCODER_EMULATOR_DIR_InBus;
  logic                  ENCODER_EMULATOR_ENCODERA_Out;
  logic                  ENCODER_EMULATOR_ENCODERB_Out;
  logic [DUTY_WIDTH-1:0] ENCODER_EMULATOR_DUTY_OutBus;
  logic                  ENCODER_EMULATOR_WINDOW_Out;
  logic [POS_WIDTH-1:0]  ENCODER_EMULATOR_POS_OutBus;

  modport master (
    output ENCODER_EMULATOR_PWMTICK_In,
    output ENCODER_EMULATOR_PWM_In,
    output ENCODER_EMULATOR_DIR_InBus,
    input  ENCODER_EMULATOR_ENCODERA_Out,
    input  ENCODER_EMULATOR_ENCODERB_Out,
    input  ENCODER_EMULATOR_DUTY_OutBus,
    input  ENCODER_EMULATOR_WINDOW_Out,
    input  ENCODER_EMULATOR_POS_OutBus
  );

  modport slave (
    input  ENCODER_EMULATOR_PWMTICK_In,
    input  ENCODER_EMULATOR_PWM_In,
    input  ENCODER_EMULATOR_DIR_InBus,
    output ENCODER_EMULATOR_ENCODERA_Out,
    output ENCODER_EMULATOR_ENCODERB_Out,
    output ENCODER_EMULATOR_DUTY_OutBus,
    output ENCODER_EMULATOR_WINDOW_Out,
    output ENCODER_EMULATOR_POS_OutBus
  );
endinterface

// File: rtl/encoder_emulator.sv
// Quadrature encoder emulator: measures PWM duty over a fixed tick window and
// turns it into A/B steps through a phase accumulator.
//
// state | meaning
// AB_00 | A=0 B=0
// AB_10 | A=1 B=0 (first forward step from 00)
// AB_11 | A=1 B=1
// AB_01 | A=0 B=1 (first reverse step from 00)
module encoder_emulator #(
  parameter int DUTY_WIDTH = 8,
  parameter int ACC_WIDTH  = 12,
  parameter int POS_WIDTH  = 16
) (
  input  logic              ENCODER_EMULATOR_CLOCK,
  input  logic              ENCODER_EMULATOR_RESET_InLow,
  encoder_emulator_if.slave bus
);

  typedef enum logic [1:0] {
    AB_00 = 2'b00,
    AB_10 = 2'b10,
    AB_11 = 2'b11,
    AB_01 = 2'b01
  } state_t;

  localparam logic [DUTY_WIDTH-1:0] WIN_LAST = '1;

  logic                  clk;
  logic                  rst_n;
  logic                  tick;
  logic                  wrap;
  logic                  moving;
  logic                  fwd;
  logic                  step;
  logic [DUTY_WIDTH-1:0] win_cnt;
  logic [DUTY_WIDTH:0]   high_cnt;
  logic [DUTY_WIDTH:0]   high_next;
  logic [DUTY_WIDTH-1:0] duty;
  logic [DUTY_WIDTH-1:0] duty_meas;
  logic                  window;
  logic [ACC_WIDTH-1:0]  acc;
  logic [ACC_WIDTH:0]    acc_sum;
  logic [POS_WIDTH-1:0]  pos;
  state_t                state;
  state_t                state_next;

  assign clk    = ENCODER_EMULATOR_CLOCK;
  assign rst_n  = ENCODER_EMULATOR_RESET_InLow;
  assign tick   = bus.ENCODER_EMULATOR_PWMTICK_In;
  assign wrap   = (win_cnt == WIN_LAST);
  assign fwd    = (bus.ENCODER_EMULATOR_DIR_InBus == 2'b01);
  assign moving = fwd || (bus.ENCODER_EMULATOR_DIR_InBus == 2'b10);

  // The high count includes the wrap-tick sample; a full window would read 2^N.
  assign high_next = high_cnt + {{DUTY_WIDTH{1'b0}}, bus.ENCODER_EMULATOR_PWM_In};
  assign duty_meas = high_next[DUTY_WIDTH] ? '1 : high_next[DUTY_WIDTH-1:0];

  assign acc_sum = {1'b0, acc} + {{(ACC_WIDTH+1-DUTY_WIDTH){1'b0}}, duty};
  assign step    = tick && moving && acc_sum[ACC_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt  <= '0;
      high_cnt <= '0;
      duty     <= '0;
      window   <= 1'b0;
    end else begin
      window <= tick && wrap;
      if (tick) begin
        win_cnt <= win_cnt + 1'b1;
        if (wrap) begin
          high_cnt <= '0;
          duty     <= duty_meas;
        end else begin
          high_cnt <= high_next;
        end
      end
    end
  end

  // Accumulator uses the duty held before this tick's window update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      pos <= '0;
    end else if (tick && moving) begin
      acc <= acc_sum[ACC_WIDTH-1:0];
      if (step) begin
        pos <= fwd ? pos + 1'b1 : pos - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= AB_00;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (step) begin
      case (state)
        AB_00:   state_next = fwd ? AB_10 : AB_01;
        AB_10:   state_next = fwd ? AB_11 : AB_00;
        AB_11:   state_next = fwd ? AB_01 : AB_10;
        AB_01:   state_next = fwd ? AB_00 : AB_11;
        default: state_next = AB_00;
      endcase
    end
  end

  assign bus.ENCODER_EMULATOR_ENCODERA_Out = state[1];
  assign bus.ENCODER_EMULATOR_ENCODERB_Out = state[0];
  assign bus.ENCODER_EMULATOR_DUTY_OutBus  = duty;
  assign bus.ENCODER_EMULATOR_WINDOW_Out   = window;
  assign bus.ENCODER_EMULATOR_POS_OutBus   = pos;

endmodule

// File: tb/tb_encoder_emulator.sv
// Directed bench for encoder_emulator: duty measurement, stepping in both
// directions, brake hold, asynchronous reset and window/step coincidence.
module tb_encoder_emulator;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   win_pos = 0;
  int   high_len = 0;
  int   pulses = 0;

  encoder_emulator_if #(.DUTY_WIDTH(8), .POS_WIDTH(16)) bus ();

  encoder_emulator #(.DUTY_WIDTH(8), .ACC_WIDTH(12), .POS_WIDTH(16)) dut (
    .ENCODER_EMULATOR_CLOCK       (clk),
    .ENCODER_EMULATOR_RESET_InLow (rst_n),
    .bus                          (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.ENCODER_EMULATOR_WINDOW_Out === 1'b1) pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ab(input string tag, input logic [1:0] ab, input logic [15:0] p);
    chk({tag, "_ab"}, {30'd0, bus.ENCODER_EMULATOR_ENCODERA_Out, bus.ENCODER_EMULATOR_ENCODERB_Out}, {30'd0, ab});
    chk({tag, "_pos"}, {16'd0, bus.ENCODER_EMULATOR_POS_OutBus}, {16'd0, p});
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.ENCODER_EMULATOR_PWM_In     = (win_pos < high_len);
      bus.ENCODER_EMULATOR_PWMTICK_In = 1'b1;
      @(negedge clk);
      bus.ENCODER_EMULATOR_PWMTICK_In = 1'b0;
      @(negedge clk);
      win_pos = (win_pos + 1) % 256;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ab"}, {30'd0, bus.ENCODER_EMULATOR_ENCODERA_Out, bus.ENCODER_EMULATOR_ENCODERB_Out}, 32'd0);
    chk({tag, "_duty"}, {24'd0, bus.ENCODER_EMULATOR_DUTY_OutBus}, 32'd0);
    chk({tag, "_pos"}, {16'd0, bus.ENCODER_EMULATOR_POS_OutBus}, 32'd0);
    chk({tag, "_window"}, {31'd0, bus.ENCODER_EMULATOR_WINDOW_Out}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.ENCODER_EMULATOR_PWMTICK_In = 1'b0;
    bus.ENCODER_EMULATOR_PWM_In     = 1'b0;
    bus.ENCODER_EMULATOR_DIR_InBus  = 2'b00;
    #1;
    chk_reset("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Window 1: PWM always high, forward requested but duty is still zero.
    bus.ENCODER_EMULATOR_DIR_InBus = 2'b01;
    high_len = 256;
    do_ticks(255);
    chk("w1_duty_before_wrap", {24'd0, bus.ENCODER_EMULATOR_DUTY_OutBus}, 32'd0);
    chk("w1_pulses_before_wrap", pulses, 0);
    chk_ab("w1_no_step_zero_duty", 2'b00, 16'h0000);
    do_ticks(1);
    chk("w1_duty_saturated", {24'd0, bus.ENCODER_EMULATOR_DUTY_OutBus}, 32'hFF);
    chk("w1_one_pulse", pulses, 1);

    // Window 2: half duty, braked so the 255 duty never steps.
    bus.ENCODER_EMULATOR_DIR_InBus = 2'b00;
    high_len = 128;
    do_ticks(256);
    chk("w2_duty_half", {24'd0, bus.ENCODER_EMULATOR_DUTY_OutBus}, 32'h80);
    chk("w2_pulses", pulses, 2);
    chk_ab("w2_brake_hold", 2'b00, 16'h0000);

    // Window 3: forward, one step every 32 ticks.
    bus.ENCODER_EMULATOR_DIR_InBus = 2'b01;
    do_ticks(31);
    chk_ab("fwd_t31", 2'b00, 16'h0000);
    do_ticks(1);
    chk_ab("fwd_t32", 2'b10, 16'h0001);
    do_ticks(32);
    chk_ab("fwd_t64", 2'b11, 16'h0002);
    do_ticks(32);
    chk_ab("fwd_t96", 2'b01, 16'h0003);
    do_ticks(32);
    chk_ab("fwd_t128", 2'b00, 16'h0004);

    // Half a step of phase, then brake, then resume from the held phase.
    do_ticks(16);
    bus.ENCODER_EMULATOR_DIR_InBus = 2'b00;
    do_ticks(100);
    chk_ab("brake_100", 2'b00, 16'h0004);
    bus.ENCODER_EMULATOR_DIR_InBus = 2'b01;
    do_ticks(15);
    chk_ab("resume_t15", 2'b00, 16'h0004);
    do_ticks(1);
    chk_ab("resume_t16", 2'b10, 16'h0005);

    // Asynchronous reset mid-activity, checked before any clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    win_pos = 0;
    pulses = 0;

    bus.ENCODER_EMULATOR_DIR_InBus = 2'b00;
    high_len = 128;
    do_ticks(256);
    chk("rst_w1_duty", {24'd0, bus.ENCODER_EMULATOR_DUTY_OutBus}, 32'h80);

    // Reverse with the next duty measured as 64.
    bus.ENCODER_EMULATOR_DIR_InBus = 2'b10;
    high_len = 64;
    do_ticks(31);
    chk_ab("rev_t31", 2'b00, 16'h0000);
    do_ticks(1);
    chk_ab("rev_t32", 2'b01, 16'hFFFF);
    do_ticks(32);
    chk_ab("rev_t64", 2'b11, 16'hFFFE);
    do_ticks(32);
    chk_ab("rev_t96", 2'b10, 16'hFFFD);
    do_ticks(159);
    chk_ab("rev_t255", 2'b10, 16'hFFF9);
    chk("rev_t255_duty_old", {24'd0, bus.ENCODER_EMULATOR_DUTY_OutBus}, 32'h80);

    // Wrap tick coincides with the eighth step, which must use the old duty.
    do_ticks(1);
    chk_ab("coinc_step", 2'b00, 16'hFFF8);
    chk("coinc_duty_new", {24'd0, bus.ENCODER_EMULATOR_DUTY_OutBus}, 32'h40);
    chk("coinc_pulses", pulses, 2);
    do_ticks(63);
    chk_ab("new_duty_t63", 2'b00, 16'hFFF8);
    do_ticks(1);
    chk_ab("new_duty_t64", 2'b01, 16'hFFF7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/encoder_emulator.md
ENCODER_EMULATOR -- requirements
Module: ENCODER_EMULATOR

Interface
REQ-001 SHALL have parameter DUTY_WIDTH, default 8, giving the width of the duty measurement and the length of the 2^DUTY_WIDTH-tick measurement window.
REQ-002 SHALL have parameter ACC_WIDTH, default 12, giving the width of the phase accumulator.
REQ-003 SHALL have parameter POS_WIDTH, default 16, giving the width of the position counter.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: ENCODER_EMULATOR_CLOCK (input, 1, system clock) and ENCODER_EMULATOR_RESET_InLow (input, 1, asynchronous active-low reset).
REQ-005 SHALL have ENCODER_EMULATOR_PWMTICK_In  input  1  one-CLOCK-wide sample strobe at the PWM generator step rate.
REQ-006 SHALL have ENCODER_EMULATOR_PWM_In  input  1  motor PWM drive, as produced by the wheel controller.
REQ-007 SHALL have ENCODER_EMULATOR_DIR_InBus  input  2  motor direction: 01 forward, 10 reverse, 00 or 11 brake.
REQ-008 SHALL have ENCODER_EMULATOR_ENCODERA_Out  output  1  emulated quadrature channel A, registered.
REQ-009 SHALL have ENCODER_EMULATOR_ENCODERB_Out  output  1  emulated quadrature channel B, registered.
REQ-010 SHALL have ENCODER_EMULATOR_DUTY_OutBus  output  DUTY_WIDTH  last measured duty count.
REQ-011 SHALL have ENCODER_EMULATOR_WINDOW_Out  output  1  one-CLOCK pulse when DUTY_OutBus updates.
REQ-012 SHALL have ENCODER_EMULATOR_POS_OutBus  output  POS_WIDTH  signed step position.

Function
REQ-013 SHALL treat each CLOCK cycle with PWMTICK_In=1 as one tick; all state except reset SHALL change only on ticks.
REQ-014 SHALL count ticks in a DUTY_WIDTH-bit window counter that wraps from 2^DUTY_WIDTH-1 to 0.
REQ-015 SHALL, in a high counter, count the ticks on which PWM_In=1.
REQ-016 SHALL, on the tick where the window counter wraps, load the duty register with the high count including the current sample, saturated to 2^DUTY_WIDTH-1.
REQ-017 SHALL, on that same wrap tick, clear the high counter and pulse WINDOW_Out on the following cycle, aligned with the DUTY_OutBus update.
REQ-018 SHALL, on each tick with DIR_InBus=01 or 10, add the zero-extended duty register to the ACC_WIDTH-bit phase accumulator, using the duty value held before any same-tick update.
REQ-019 SHALL generate a step event from a carry out of the phase accumulator; the accumulator SHALL keep the wrapped remainder.
REQ-020 SHALL hold the accumulator and suppress steps when DIR_InBus is 00 or 11.
REQ-021 SHALL implement a 4-state quadrature FSM over AB in {00,10,11,01}.
REQ-022 SHALL advance the FSM on a forward step as 00->10->11->01->00, so that A leads B.
REQ-023 SHALL advance the FSM on a reverse step as 00->01->11->10->00.
REQ-024 SHALL change AB by exactly one bit per step and never skip a state.
REQ-025 SHALL drive the A/B outputs from the FSM state register with no combinational path from inputs.
REQ-026 SHALL increment POS_OutBus by 1 on each forward step and decrement it by 1 on each reverse step, with two's-complement wrap.
REQ-027 SHALL sample DIR_InBus at each step event; a direction change SHALL take effect on the next step from the current AB state.
REQ-028 SHALL produce at most one step per tick, which holds because duty < 2^ACC_WIDTH.

Reset
REQ-029 SHALL, while RESET_InLow=0, asynchronously force A=0, B=0, FSM=00, DUTY_OutBus=0, WINDOW_Out=0, POS_OutBus=0, window counter=0, high counter=0 and accumulator=0.
REQ-030 SHALL, after reset release, start the first window at the next tick, with no steps generated until a nonzero duty has been loaded.
REQ-031 SHALL, when reset is asserted mid-window or mid-step, discard the partial window, the accumulator and the pending direction.

Verification
REQ-032 SHALL cover: reset pulse during activity -> A=B=0, DUTY=0, POS=0 immediately, with no clock required.
REQ-033 SHALL cover: PWM_In=1 for 256 ticks -> DUTY=255 (saturated) and one WINDOW pulse.
REQ-034 SHALL cover: 128 high of 256 ticks, then DIR=01 -> DUTY=128; a step every 32 ticks, first at tick 32 of the next window; AB sequence 00,10,11,01,00; POS=4 after 128 ticks.
REQ-035 SHALL cover: DUTY=128 with DIR=10 starting from POS=0 -> AB sequence 00,01,11,10; POS=0xFFFF after the first step.
REQ-036 SHALL cover: DIR switched 01->00 for 100 ticks, then back to 01 -> no AB change and POS constant during brake; stepping resumes from the held accumulator value.
REQ-037 SHALL cover: window end and step on the same tick -> the step uses the old duty, and the new DUTY value is applied from the next tick.
